seg_scan_ctrl: RTL and testbench

Time-multiplexing scan controller that shares one 4-bit-to-7-segment decode path across `NUM_DIGITS` common-anode/cathode digit positions. Upstream logic writes per-digit values, optionally Gray-encoding them on entry, through a valid/ready port. The controller double-buffers them and scans the digits with a blanking gap to suppress ghosting. It sits between the binary-to-Gray datapath and the board's segment and digit-enable pins.

---
 rtl/seg_pkg.sv | 25 ++
 rtl/hex_to_seg.sv | 11 +
 rtl/seg_scan_ctrl.sv | 127 ++++++++++++
 tb/tb_seg_scan_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the segment scan controller: FSM states,
// the hex-to-segment table (gfedcba, active-high) and the Gray encoder.
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        SHOW,
        COMMIT
    } scan_state_e;

    localparam logic [6:0] SEG_OFF = 7'b0000000;

    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };

    function automatic logic [3:0] gray_enc(input logic [3:0] v);
        return v ^ (v >> 1);
    endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Combinational 4-bit to 7-segment decoder backed by the package table.
module hex_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[value];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller with double-buffered digit values,
// a blanking gap before each digit, and a one-cycle commit between frames.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [$clog2(NUM_DIGITS)-1:0] wr_digit,
    input  logic [3:0]                    wr_value,
    input  logic                          wr_gray,
    output logic [6:0]                    seven_segment,
    output logic [NUM_DIGITS-1:0]         digit_en,
    output logic                          frame_done
);

    localparam int DW   = $clog2(NUM_DIGITS);
    localparam int MAXC = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CW   = $clog2(MAXC) + 1;

    scan_state_e   state, state_n;
    logic [DW-1:0] digit, digit_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0]    shadow [NUM_DIGITS];
    logic [3:0]    active [NUM_DIGITS];
    logic [6:0]    dec_seg;

    assign wr_ready   = (state != COMMIT);
    assign frame_done = (state == COMMIT);

    // Decode the digit that will be on the pins after this edge, so the
    // segment and enable registers always load as a matched pair.
    hex_to_seg u_dec (
        .value (active[digit_n]),
        .seg   (dec_seg)
    );

    always_comb begin
        state_n = state;
        digit_n = digit;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                digit_n = '0;
                cnt_n   = '0;
                if (enable) begin
                    state_n = BLANK;
                    cnt_n   = CW'(BLANK_CYCLES);
                end
            end
            BLANK: begin
                if (cnt == CW'(1)) begin
                    state_n = SHOW;
                    cnt_n   = CW'(REFRESH_DIV);
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            SHOW: begin
                if (cnt == CW'(1)) begin
                    if (digit == DW'(NUM_DIGITS - 1)) begin
                        state_n = COMMIT;
                        cnt_n   = CW'(1);
                    end else begin
                        state_n = BLANK;
                        digit_n = digit + 1'b1;
                        cnt_n   = CW'(BLANK_CYCLES);
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            COMMIT: begin
                state_n = BLANK;
                digit_n = '0;
                cnt_n   = CW'(BLANK_CYCLES);
            end
            default: state_n = IDLE;
        endcase
        // Dropping enable stops the scan from any state; a COMMIT in
        // progress still copies shadow to active on this same edge.
        if (!enable) begin
            state_n = IDLE;
            digit_n = '0;
            cnt_n   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            digit         <= '0;
            cnt           <= '0;
            seven_segment <= SEG_OFF;
            digit_en      <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            state <= state_n;
            digit <= digit_n;
            cnt   <= cnt_n;
            if (state_n == SHOW) begin
                seven_segment <= dec_seg;
                digit_en      <= {{(NUM_DIGITS-1){1'b0}}, 1'b1} << digit_n;
            end else begin
                seven_segment <= SEG_OFF;
                digit_en      <= '0;
            end
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (state == IDLE || state == COMMIT)
                    active[i] <= shadow[i];
                // Out-of-range indices match no entry and are dropped.
                if (wr_valid && wr_ready && wr_digit == DW'(i))
                    shadow[i] <= wr_gray ? gray_enc(wr_value) : wr_value;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: a frame-position model predicts every
// cycle's pins, and a monitor compares them against the DUT.
module tb_seg_scan_ctrl;

    localparam int ND    = 4;
    localparam int RDIV  = 4;
    localparam int BLK   = 2;
    localparam int SLOT  = BLK + RDIV;
    localparam int FRAME = ND * SLOT + 1;

    typedef struct packed {
        logic [6:0] seg;
        logic [3:0] den;
        logic       fd;
        logic       rdy;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       wr_valid;
    logic       wr_ready;
    logic [1:0] wr_digit;
    logic [3:0] wr_value;
    logic       wr_gray;
    logic [6:0] seven_segment;
    logic [3:0] digit_en;
    logic       frame_done;

    int   checks = 0;
    int   fails  = 0;
    int   cyc    = 0;
    exp_t q [$];

    seg_scan_ctrl #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RDIV),
        .BLANK_CYCLES(BLK)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_digit     (wr_digit),
        .wr_value     (wr_value),
        .wr_gray      (wr_gray),
        .seven_segment(seven_segment),
        .digit_en     (digit_en),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ref_seg(input logic [3:0] v);
        case (v)
            4'h0: return 7'b0111111;  4'h1: return 7'b0000110;
            4'h2: return 7'b1011011;  4'h3: return 7'b1001111;
            4'h4: return 7'b1100110;  4'h5: return 7'b1101101;
            4'h6: return 7'b1111101;  4'h7: return 7'b0000111;
            4'h8: return 7'b1111111;  4'h9: return 7'b1101111;
            4'hA: return 7'b1110111;  4'hB: return 7'b1111100;
            4'hC: return 7'b0111001;  4'hD: return 7'b1011110;
            4'hE: return 7'b1111001;  default: return 7'b1110001;
        endcase
    endfunction

    // Reference model: position within the frame since scanning started.
    bit         m_run = 1'b0;
    int         m_pos = 0;
    logic [3:0] m_sh [ND];
    logic [3:0] m_ac [ND];

    initial begin
        bit   commit_now;
        int   d;
        exp_t e;
        forever begin
            @(posedge clk);
            commit_now = m_run && (m_pos == FRAME - 1);
            if (rst) begin
                m_run = 1'b0;
                m_pos = 0;
                for (int i = 0; i < ND; i++) begin
                    m_sh[i] = '0;
                    m_ac[i] = '0;
                end
            end else begin
                if (!m_run || commit_now)
                    for (int i = 0; i < ND; i++) m_ac[i] = m_sh[i];
                if (wr_valid && !commit_now)
                    m_sh[wr_digit] = wr_gray ? (wr_value ^ (wr_value >> 1)) : wr_value;
                if (!enable) begin
                    m_run = 1'b0;
                    m_pos = 0;
                end else if (!m_run) begin
                    m_run = 1'b1;
                    m_pos = 0;
                end else begin
                    m_pos = (m_pos + 1) % FRAME;
                end
            end
            e = '{seg: 7'd0, den: 4'd0, fd: 1'b0, rdy: 1'b1};
            if (m_run) begin
                if (m_pos == FRAME - 1) begin
                    e.fd  = 1'b1;
                    e.rdy = 1'b0;
                end else if (m_pos % SLOT >= BLK) begin
                    d     = m_pos / SLOT;
                    e.den = 4'(1 << d);
                    e.seg = ref_seg(m_ac[d]);
                end
            end
            q.push_back(e);
        end
    end

    // Monitor: pins are sampled mid-cycle against the queued prediction.
    initial begin
        exp_t e;
        exp_t a;
        forever begin
            @(negedge clk);
            cyc++;
            if (q.size() > 0) begin
                e = q.pop_front();
                a = '{seg: seven_segment, den: digit_en, fd: frame_done, rdy: wr_ready};
                checks++;
                if (a !== e) begin
                    fails++;
                    $display("FAIL pins cyc %0d: got seg=%b en=%b fd=%b rdy=%b, expected seg=%b en=%b fd=%b rdy=%b",
                             cyc, a.seg, a.den, a.fd, a.rdy, e.seg, e.den, e.fd, e.rdy);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write(input logic [1:0] d, input logic [3:0] v, input logic g);
        int n = 0;
        wr_valid = 1'b1;
        wr_digit = d;
        wr_value = v;
        wr_gray  = g;
        while (wr_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        wr_valid = 1'b0;
        checks++;
        if (n >= 100) begin
            fails++;
            $display("FAIL write_accept: wr_ready stayed %b, required 1", wr_ready);
        end
    endtask

    task automatic wait_den(input logic [3:0] v);
        int n = 0;
        while (digit_en !== v && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 200) begin
            fails++;
            $display("FAIL wait_digit_en: got %b, required %b", digit_en, v);
        end
    endtask

    task automatic wait_commit();
        int n = 0;
        while (frame_done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 200) begin
            fails++;
            $display("FAIL wait_frame_done: got %b, required 1", frame_done);
        end
    endtask

    initial begin
        rst      = 1'b1;
        enable   = 1'b1;
        wr_valid = 1'b0;
        wr_digit = '0;
        wr_value = '0;
        wr_gray  = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(2 * FRAME);

        // Gray-encoded write while idle
        enable = 1'b0;
        tick(2);
        write(2'd1, 4'b0110, 1'b1);
        enable = 1'b1;
        tick(FRAME + 5);

        // Scan order with distinct values
        enable = 1'b0;
        for (int i = 0; i < ND; i++) write(2'(i), 4'(i + 1), 1'b0);
        enable = 1'b1;
        tick(2 * FRAME + 3);

        // Mid-frame write must not tear the current frame
        wait_den(4'b0010);
        write(2'd0, 4'hA, 1'b0);
        tick(2 * FRAME);

        // Write presented during COMMIT stalls one cycle
        wait_commit();
        write(2'd3, 4'hF, 1'b0);
        tick(2 * FRAME);

        // Enable drop mid-SHOW of digit 2, then restart
        wait_den(4'b0100);
        enable = 1'b0;
        tick(5);
        enable = 1'b1;
        tick(FRAME + 10);

        // Randomized traffic
        for (int it = 0; it < 80; it++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5:
                    write(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
                6: begin
                    enable = ~enable;
                    tick($urandom_range(1, 8));
                end
                7: begin
                    rst = 1'b1;
                    tick(1);
                    rst = 1'b0;
                end
                default: tick($urandom_range(1, 20));
            endcase
            if (!enable && $urandom_range(0, 2) == 0) enable = 1'b1;
        end
        enable = 1'b1;
        tick(2 * FRAME);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
